// File: rtl/wishbone_initiator_pkg.sv
// Shared types and the alignment rule for the Wishbone single-transfer initiator.
package wishbone_initiator_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Size code 3 has no legal meaning and is reported like a misaligned access.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = a[0];
            2'd2:    misaligned = |a;
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/wishbone_initiator_if.sv
// Wishbone classic bus signals between the initiator (master) and memory_controller (slave).
interface wishbone_initiator_if;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic [3:0]  SEL_O;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        ACK_I;

    modport master (output CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O,
                    input  DAT_I, ACK_I);
    modport slave  (input  CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O,
                    output DAT_I, ACK_I);
endinterface

// File: rtl/wishbone_initiator_lane.sv
// Combinational lane steering: store SEL/data placement and load extraction/extension.
module wb_lane_align
    import wishbone_initiator_pkg::*;
(
    input  size_t       st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  size_t       ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_data_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        sel_o = 4'h0;
        dat_o = st_data_i;
        case (st_size_i)
            SIZE_BYTE: begin
                sel_o = 4'b0001 << st_off_i;
                dat_o = {4{st_data_i[7:0]}};
            end
            SIZE_HALF: begin
                sel_o = 4'b0011 << st_off_i;
                dat_o = {2{st_data_i[15:0]}};
            end
            SIZE_WORD: sel_o = 4'hF;
            default:   sel_o = 4'h0;
        endcase
    end

    always_comb begin
        case (ld_off_i)
            2'd1:    ld_byte = ld_data_i[15:8];
            2'd2:    ld_byte = ld_data_i[23:16];
            2'd3:    ld_byte = ld_data_i[31:24];
            default: ld_byte = ld_data_i[7:0];
        endcase
        ld_half = ld_off_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
    end

    always_comb begin
        case (ld_size_i)
            SIZE_BYTE: ld_data_o = {{24{~ld_unsigned_i & ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data_o = {{16{~ld_unsigned_i & ld_half[15]}}, ld_half};
            default:   ld_data_o = ld_data_i;
        endcase
    end

endmodule

// File: rtl/wishbone_initiator.sv
// Turns one load/store request from the core into exactly one Wishbone classic cycle,
// with misalignment and no-ACK timeout reported as a one-cycle err pulse.
module wishbone_initiator
    import wishbone_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    wishbone_initiator_if.master wb
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic        cyc_q, we_q, busy_q, done_q, err_q, uns_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q, dat_q, rd_q;
    size_t       size_q;
    logic [1:0]  off_q;

    logic        req;
    logic [3:0]  sel_d;
    logic [31:0] dat_d, rd_d;

    assign req = rd_en | wr_en;

    wb_lane_align u_lane (
        .st_size_i     (size_t'(size)),
        .st_off_i      (addr[1:0]),
        .st_data_i     (wr_data),
        .sel_o         (sel_d),
        .dat_o         (dat_d),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (uns_q),
        .ld_data_i     (wb.DAT_I),
        .ld_data_o     (rd_d)
    );

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            uns_q   <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
            rd_q    <= 32'h0;
            size_q  <= SIZE_BYTE;
            off_q   <= 2'b00;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                // RESP accepts like IDLE so a held request starts on the edge leaving RESP.
                IDLE, RESP: begin
                    state_q <= IDLE;
                    if (req) begin
                        if (misaligned(size, addr[1:0])) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= BUS;
                            cyc_q   <= 1'b1;
                            we_q    <= wr_en;
                            sel_q   <= sel_d;
                            adr_q   <= {addr[31:2], 2'b00};
                            dat_q   <= dat_d;
                            size_q  <= size_t'(size);
                            uns_q   <= unsigned_ld;
                            off_q   <= addr[1:0];
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                end
                BUS: begin
                    if (wb.ACK_I) begin
                        if (!we_q) rd_q <= rd_d;
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= RESP;
                    end else if (cnt_q == TO_LAST) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb.CYC_O = cyc_q;
    assign wb.STB_O = cyc_q;
    assign wb.WE_O  = we_q;
    assign wb.SEL_O = sel_q;
    assign wb.ADR_O = adr_q;
    assign wb.DAT_O = dat_q;
    assign rd_data  = rd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
